pkt_wr_arbiter: RTL and testbench
=================================

PKT_WR_ARBITER -- requirements
Module: pkt_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of ingress requesters (2-8).
REQ-002 Parameter W_EL, default 20: data width; matches the FIFO element width.
REQ-003 Parameter WDOG_CYCLES, default 256: watchdog stall limit in cycles (1-65535).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester beat valid.
REQ-007 req_data  in  NUM_REQ*W_EL  per-requester beat data; requester i occupies bits [i*W_EL +: W_EL].
REQ-008 req_last  in  NUM_REQ  per-requester end-of-packet marker, qualified by req_valid.
REQ-009 req_ready  out  NUM_REQ  per-requester beat accept.
REQ-010 fifo_wdata  out  W_EL  write data to the FIFO.
REQ-011 fifo_wen  out  1  write enable to the FIFO.
REQ-012 fifo_full  in  1  FIFO full flag.
REQ-013 grant_valid  out  1  a packet grant is held.
REQ-014 grant_id  out  clog2(NUM_REQ)  index of the granted requester.
REQ-015 wdog_err  out  1  one-cycle pulse on a watchdog abort; present only when the watchdog is compiled in.

Function
REQ-016 FSM states: IDLE and LOCKED.
REQ-017 IDLE: on any req_valid set, the SHALL register the round-robin winner into grant_id and move to LOCKED on the next edge; req_ready is all-zero in IDLE.
REQ-018 Round-robin: the search starts at the index after the last granted requester and wraps from NUM_REQ-1 to 0; after reset the search starts at index 0.
REQ-019 LOCKED: req_ready[grant_id] = !fifo_full; all other req_ready bits are 0.
REQ-020 LOCKED: fifo_wen = req_valid[grant_id] && !fifo_full; fifo_wdata = req_data of grant_id; both are combinational, with zero-cycle latency from the beat to the FIFO.
REQ-021 A beat transfers when fifo_wen is 1.
REQ-022 A transfer with req_last = 1 returns the FSM to IDLE on the next edge; the next grant therefore starts no earlier than 2 cycles after the last beat.
REQ-023 Grants are packet-granular: no requester change inside a packet, whatever other requesters assert.
REQ-024 fifo_full asserted mid-packet: the grant is held and no beat is dropped or duplicated.
REQ-025 A single-beat packet (first beat with req_last = 1) is legal.
REQ-026 fifo_wen SHALL never be 1 while fifo_full is 1.
REQ-027 fifo_wdata SHALL be 0 whenever fifo_wen is 0.

Reset
REQ-028 reset_n low asynchronously forces: IDLE, grant_valid = 0, grant_id = 0, RR pointer = 0, req_ready = 0, fifo_wen = 0, wdog_err = 0, watchdog counter = 0.
REQ-029 Reset mid-packet abandons the packet with no further FIFO write; recovery of the FIFO pointers is the owner's responsibility.
REQ-030 Deassertion of reset_n is synchronised externally; the block leaves IDLE no earlier than the first edge after deassertion.

Configuration
REQ-031 Macro PKT_WR_ARBITER_WDOG_EN.
REQ-032 With PKT_WR_ARBITER_WDOG_EN defined:
  - a 16-bit counter increments each LOCKED cycle with no transfer, and clears on any transfer or in IDLE;
  - when the counter reaches WDOG_CYCLES, the FSM returns to IDLE, wdog_err pulses for 1 cycle, and the RR pointer advances past the stalled requester.
REQ-033 Without PKT_WR_ARBITER_WDOG_EN: no counter, the wdog_err port is absent, and a grant is held indefinitely.

Structure
REQ-034 Package pkt_wr_arbiter_pkg holds the FSM state enum, the default NUM_REQ, W_EL and WDOG_CYCLES values, and the REQ_ID_W = clog2(NUM_REQ) function.
REQ-035 One combinational sub-module, rr_pick: inputs are a request vector and a start index; outputs are the winner index and a found flag.

Verification
REQ-036 Arbitration and latency: req_valid = 4'b0110, reset RR pointer, 3-beat packets with data 0x00011/12/13:
  - grant_id = 1 one cycle after the request;
  - 3 fifo_wen pulses with data 11, 12, 13;
  - then grant_id = 2.
REQ-037 Fairness: all 4 requesters continuously offer 1-beat packets -> grant order 0, 1, 2, 3, 0, with one packet each.
REQ-038 Backpressure: fifo_full = 1 for 5 cycles during beat 2 of 4 -> fifo_wen = 0 and req_ready = 0 for those cycles, beats 2-4 are written exactly once, and the grant is unchanged.
REQ-039 Mid-packet reset: reset_n = 0 after beat 2 -> all outputs at reset values within the same cycle, and no further writes.
REQ-040 Watchdog (macro defined, WDOG_CYCLES = 8):
  - granted requester 0 drops req_valid mid-packet;
  - wdog_err pulses after 8 idle cycles;
  - requester 1 is granted next.
REQ-041 Single-beat packets back-to-back from requester 3 alone -> one write per 2 cycles at most, with grant_id = 3 each time.

Source files
------------

// File: rtl/pkt_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pkt_wr_arbiter_pkg
// Shared definitions for the packet write arbiter:
//   - arbState_t      : arbiter FSM states (IDLE, LOCKED)
//   - DEF_NUM_REQ     : default number of ingress requesters
//   - DEF_W_EL        : default FIFO element / beat width
//   - DEF_WDOG_CYCLES : default watchdog stall limit
//   - WDOG_CNT_W      : width of the watchdog stall counter
//   - REQ_ID_W()      : width of a requester index for a given NUM_REQ
// ---------------------------------------------------------------------------
package pkt_wr_arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arbState_t;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_W_EL        = 20;
   localparam int DEF_WDOG_CYCLES = 256;
   localparam int WDOG_CNT_W      = 16;

   // clog2 of the requester count, never less than one bit so that a
   // two-requester build still has a usable index.
   function automatic int REQ_ID_W(input int numReq);
      return (numReq <= 2) ? 1 : $clog2(numReq);
   endfunction

endpackage

// File: rtl/pkt_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans the request vector starting at
// i_start and wrapping from NUM_REQ-1 back to 0; the first set bit found is
// the winner.
// Ports:
//   i_req    [NUM_REQ-1:0] request vector
//   i_start  [ID_W-1:0]    index at which the search begins
//   o_winner [ID_W-1:0]    index of the first request found (0 if none)
//   o_found                at least one request is set
// ---------------------------------------------------------------------------
module rr_pick
   import pkt_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = REQ_ID_W(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_start,
   output logic [ID_W-1:0]    o_winner,
   output logic               o_found
);

   logic [ID_W-1:0] w_idx;

   // Walk the candidates from farthest to nearest so that the last match
   // written is the one closest to i_start, i.e. the round-robin winner.
   always_comb begin
      o_found  = 1'b0;
      o_winner = '0;
      w_idx    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = ID_W'((int'(i_start) + k) % NUM_REQ);
         if (i_req[w_idx]) begin
            o_found  = 1'b1;
            o_winner = w_idx;
         end
      end
   end

endmodule

// File: rtl/pkt_wr_arbiter.sv
// ---------------------------------------------------------------------------
// pkt_wr_arbiter
// Packet-granular round-robin arbiter that merges NUM_REQ ingress beat
// streams into a single FIFO write port. A requester holds the grant from
// its first beat until the beat carrying req_last has been written.
//
// Optional feature (macro PKT_WR_ARBITER_WDOG_EN): a stall watchdog that
// aborts a grant after WDOG_CYCLES consecutive LOCKED cycles without a
// transfer and pulses wdog_err. Without the macro the port does not exist
// and a grant is held for as long as the requester takes.
//
// Ports:
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   req_valid    [NUM_REQ]      per-requester beat valid
//   req_data     [NUM_REQ*W_EL] per-requester beat data, lane i at [i*W_EL +: W_EL]
//   req_last     [NUM_REQ]      per-requester end-of-packet marker
//   req_ready    [NUM_REQ]      per-requester beat accept
//   fifo_wdata   [W_EL]         FIFO write data (zero when not writing)
//   fifo_wen                    FIFO write enable
//   fifo_full                   FIFO full flag
//   grant_valid                 a packet grant is held
//   grant_id     [REQ_ID_W]     index of the granted requester
//   wdog_err                    one-cycle watchdog abort pulse (macro only)
// ---------------------------------------------------------------------------
module pkt_wr_arbiter
   import pkt_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int W_EL        = DEF_W_EL,
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*W_EL-1:0]        req_data,
   input  logic [NUM_REQ-1:0]             req_last,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [W_EL-1:0]                fifo_wdata,
   output logic                           fifo_wen,
   input  logic                           fifo_full,
   output logic                           grant_valid,
   output logic [REQ_ID_W(NUM_REQ)-1:0]   grant_id
`ifdef PKT_WR_ARBITER_WDOG_EN
   ,
   output logic                           wdog_err
`endif
);

   localparam int ID_W = REQ_ID_W(NUM_REQ);

   // Elaboration-time guard on the supported configuration range.
   if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_badConfig
      $error("pkt_wr_arbiter: NUM_REQ or WDOG_CYCLES outside supported range");
   end

   arbState_t       r_state;
   arbState_t       w_nextState;
   logic [ID_W-1:0] r_grantId;
   logic [ID_W-1:0] r_rrPtr;
   logic [ID_W-1:0] w_winner;
   logic            w_found;
   logic            w_xfer;
   logic            w_wdogHit;
   logic [W_EL-1:0] w_reqData [NUM_REQ];

   // Index following idx, wrapping to 0 after the last requester.
   function automatic logic [ID_W-1:0] incWrap(input logic [ID_W-1:0] idx);
      if (int'(idx) >= NUM_REQ - 1) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_reqData[g] = req_data[g*W_EL +: W_EL];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rrPick (
      .i_req    (req_valid),
      .i_start  (r_rrPtr),
      .o_winner (w_winner),
      .o_found  (w_found)
   );

   // A beat moves only while locked, the owner offers it and the FIFO has room.
   assign w_xfer      = (r_state == LOCKED) && req_valid[r_grantId] && !fifo_full;
   assign grant_valid = (r_state == LOCKED);
   assign grant_id    = r_grantId;

`ifdef PKT_WR_ARBITER_WDOG_EN
   logic [WDOG_CNT_W-1:0] r_wdogCnt;
   logic                  r_wdogErr;

   // The hit fires on the WDOG_CYCLES-th consecutive stalled cycle, so the
   // abort edge is the one at which the count would reach WDOG_CYCLES.
   assign w_wdogHit = (r_state == LOCKED) && !w_xfer &&
                      (r_wdogCnt == WDOG_CNT_W'(WDOG_CYCLES - 1));

   // Stall counter and abort pulse; both clear on any transfer or in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wdogCnt <= '0;
         r_wdogErr <= 1'b0;
      end else begin
         r_wdogErr <= w_wdogHit;
         if ((r_state == LOCKED) && !w_xfer && !w_wdogHit) begin
            r_wdogCnt <= r_wdogCnt + 1'b1;
         end else begin
            r_wdogCnt <= '0;
         end
      end
   end

   assign wdog_err = r_wdogErr;
`else
   assign w_wdogHit = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Grant and round-robin pointer. The pointer moves past the winner at
   // grant time, which also covers the watchdog case: an aborted requester
   // is already behind the search start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_grantId <= '0;
         r_rrPtr   <= '0;
      end else if ((r_state == IDLE) && w_found) begin
         r_grantId <= w_winner;
         r_rrPtr   <= incWrap(w_winner);
      end
   end

   // Next-state and datapath outputs; everything is quiet in IDLE.
   always_comb begin
      w_nextState = r_state;
      req_ready   = '0;
      fifo_wen    = 1'b0;
      fifo_wdata  = '0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_nextState = LOCKED;
            end
         end
         LOCKED: begin
            req_ready[r_grantId] = !fifo_full;
            fifo_wen             = w_xfer;
            if (w_xfer) begin
               fifo_wdata = w_reqData[r_grantId];
            end
            if ((w_xfer && req_last[r_grantId]) || w_wdogHit) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pkt_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pkt_wr_arbiter
// Self-checking bench for pkt_wr_arbiter (NUM_REQ=4, W_EL=20, WDOG_CYCLES=8).
// A cycle-by-cycle vector table covers arbitration, latency, backpressure on
// a single beat, mid-packet reset and RR pointer reset. Hand-written
// sequences cover fairness, multi-cycle backpressure, back-to-back single
// beats and the watchdog (PKT_WR_ARBITER_WDOG_EN) or grant hold without it.
// FIFO writes in the sequences are checked against a queue of expected
// {grant_id, data} entries filled when the stimulus is set up.
// ---------------------------------------------------------------------------
module tb_pkt_wr_arbiter;
   import pkt_wr_arbiter_pkg::*;

   localparam int NR   = 4;
   localparam int W    = 20;
   localparam int WDOG = 8;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [NR-1:0]   req_valid;
   logic [NR*W-1:0] req_data;
   logic [NR-1:0]   req_last;
   logic [NR-1:0]   req_ready;
   logic [W-1:0]    fifo_wdata;
   logic            fifo_wen;
   logic            fifo_full;
   logic            grant_valid;
   logic [1:0]      grant_id;
`ifdef PKT_WR_ARBITER_WDOG_EN
   logic            wdog_err;
`endif

   always #5 clk = ~clk;

   pkt_wr_arbiter #(
      .NUM_REQ     (NR),
      .W_EL        (W),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .fifo_wdata  (fifo_wdata),
      .fifo_wen    (fifo_wen),
      .fifo_full   (fifo_full),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
`ifdef PKT_WR_ARBITER_WDOG_EN
      ,
      .wdog_err    (wdog_err)
`endif
   );

   typedef struct packed {
      logic [3:0]  ready;
      logic        wen;
      logic [19:0] wdata;
      logic        gv;
      logic [1:0]  gid;
   } outs_t;

   typedef struct {
      logic        rstn;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic        full;
      logic [79:0] data;
      outs_t       exp;
   } vec_t;

   typedef struct packed {
      logic [1:0]  id;
      logic [19:0] data;
   } wr_t;

   vec_t  vecs[$];
   outs_t expQ[$];
   wr_t   wrQ[$];
   int    nVec  = 0;
   int    nErr  = 0;
   int    cycle = 0;
   bit    monEn = 1'b0;

   // Free-running cycle count used to measure spacing between writes.
   always @(posedge clk) cycle++;

   function automatic logic [79:0] packData(input logic [19:0] d0, input logic [19:0] d1,
                                            input logic [19:0] d2, input logic [19:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   function automatic logic [79:0] place(input int lane, input logic [19:0] d);
      return 80'(d) << (20 * lane);
   endfunction

   function automatic outs_t actual();
      outs_t a;
      a.ready = req_ready;
      a.wen   = fifo_wen;
      a.wdata = fifo_wdata;
      a.gv    = grant_valid;
      a.gid   = grant_id;
      return a;
   endfunction

   task automatic addVec(input logic rstn, input logic [3:0] valid, input logic [3:0] last,
                         input logic full, input logic [79:0] data, input logic [3:0] ready,
                         input logic wen, input logic [19:0] wdata, input logic gv,
                         input logic [1:0] gid);
      vec_t v;
      v.rstn      = rstn;
      v.valid     = valid;
      v.last      = last;
      v.full      = full;
      v.data      = data;
      v.exp.ready = ready;
      v.exp.wen   = wen;
      v.exp.wdata = wdata;
      v.exp.gv    = gv;
      v.exp.gid   = gid;
      vecs.push_back(v);
   endtask

   // Drive one vector just after the rising edge and queue its expectation.
   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      reset_n   = v.rstn;
      req_valid = v.valid;
      req_last  = v.last;
      fifo_full = v.full;
      req_data  = v.data;
      expQ.push_back(v.exp);
   endtask

   // Compare outputs mid-cycle against the oldest queued expectation.
   task automatic checkOutput(input string name);
      outs_t e;
      outs_t a;
      @(negedge clk);
      e = expQ.pop_front();
      a = actual();
      nVec++;
      if (a !== e) begin
         nErr++;
         $display("[TB] FAIL %s: got ready=%b wen=%b wdata=%h gv=%b gid=%0d, expected ready=%b wen=%b wdata=%h gv=%b gid=%0d",
                  name, a.ready, a.wen, a.wdata, a.gv, a.gid, e.ready, e.wen, e.wdata, e.gv, e.gid);
      end
   endtask

   task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
      nVec++;
      if (got !== want) begin
         nErr++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      reset_n   = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
   endtask

   // Write scoreboard: every FIFO write in the sequences must match the
   // oldest expected {grant_id, data}; writes with nothing expected are errors.
   always @(negedge clk) begin
      wr_t e;
      if (monEn && fifo_wen === 1'b1) begin
         nVec++;
         if (wrQ.size() == 0) begin
            nErr++;
            $display("[TB] FAIL unexpectedWrite: got id=%0d data=%h, expected no write", grant_id, fifo_wdata);
         end else begin
            e = wrQ.pop_front();
            if ({grant_id, fifo_wdata} !== {e.id, e.data}) begin
               nErr++;
               $display("[TB] FAIL fifoWrite: got id=%0d data=%h, expected id=%0d data=%h",
                        grant_id, fifo_wdata, e.id, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: got no finish, expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      int k;
      int budget;
      int fullLeft;
      int lastCyc;
      int n;
      bit seen;

      reset_n   = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;

      // rstn valid last full data | ready wen wdata gv gid
      addVec(0, 4'b0110, 4'b0000, 0, packData(20'h0, 20'h11, 20'h21, 20'h0), 4'b0000, 0, 20'h0,  0, 0);
      addVec(1, 4'b0110, 4'b0000, 0, packData(20'h0, 20'h11, 20'h21, 20'h0), 4'b0000, 0, 20'h0,  0, 0);
      addVec(1, 4'b0110, 4'b0000, 0, packData(20'h0, 20'h11, 20'h21, 20'h0), 4'b0010, 1, 20'h11, 1, 1);
      addVec(1, 4'b0110, 4'b0000, 0, packData(20'h0, 20'h12, 20'h21, 20'h0), 4'b0010, 1, 20'h12, 1, 1);
      addVec(1, 4'b0110, 4'b0010, 0, packData(20'h0, 20'h13, 20'h21, 20'h0), 4'b0010, 1, 20'h13, 1, 1);
      addVec(1, 4'b0100, 4'b0000, 0, packData(20'h0, 20'h0,  20'h21, 20'h0), 4'b0000, 0, 20'h0,  0, 1);
      addVec(1, 4'b0100, 4'b0000, 0, packData(20'h0, 20'h0,  20'h21, 20'h0), 4'b0100, 1, 20'h21, 1, 2);
      addVec(1, 4'b0100, 4'b0100, 0, packData(20'h0, 20'h0,  20'h22, 20'h0), 4'b0100, 1, 20'h22, 1, 2);
      addVec(1, 4'b0000, 4'b0000, 0, packData(20'h0, 20'h0,  20'h0,  20'h0), 4'b0000, 0, 20'h0,  0, 2);
      addVec(1, 4'b0001, 4'b0000, 0, packData(20'h31, 20'h0, 20'h0,  20'h0), 4'b0000, 0, 20'h0,  0, 2);
      addVec(1, 4'b0001, 4'b0000, 0, packData(20'h31, 20'h0, 20'h0,  20'h0), 4'b0001, 1, 20'h31, 1, 0);
      addVec(1, 4'b0001, 4'b0000, 0, packData(20'h32, 20'h0, 20'h0,  20'h0), 4'b0001, 1, 20'h32, 1, 0);
      addVec(0, 4'b0001, 4'b0000, 0, packData(20'h33, 20'h0, 20'h0,  20'h0), 4'b0000, 0, 20'h0,  0, 0);
      addVec(0, 4'b0001, 4'b0000, 0, packData(20'h33, 20'h0, 20'h0,  20'h0), 4'b0000, 0, 20'h0,  0, 0);
      addVec(1, 4'b0011, 4'b0000, 0, packData(20'h41, 20'h51, 20'h0, 20'h0), 4'b0000, 0, 20'h0,  0, 0);
      addVec(1, 4'b0011, 4'b0001, 0, packData(20'h41, 20'h51, 20'h0, 20'h0), 4'b0001, 1, 20'h41, 1, 0);
      addVec(1, 4'b0011, 4'b0000, 0, packData(20'h42, 20'h51, 20'h0, 20'h0), 4'b0000, 0, 20'h0,  0, 0);
      addVec(1, 4'b0011, 4'b0010, 1, packData(20'h42, 20'h51, 20'h0, 20'h0), 4'b0000, 0, 20'h0,  1, 1);
      addVec(1, 4'b0011, 4'b0010, 0, packData(20'h42, 20'h51, 20'h0, 20'h0), 4'b0010, 1, 20'h51, 1, 1);
      addVec(1, 4'b0001, 4'b0000, 0, packData(20'h42, 20'h0, 20'h0,  20'h0), 4'b0000, 0, 20'h0,  0, 1);
      addVec(1, 4'b0000, 4'b0000, 0, packData(20'h0,  20'h0, 20'h0,  20'h0), 4'b0001, 0, 20'h0,  1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i));
      end

      // Fairness: every requester offers single-beat packets continuously.
      doReset();
      monEn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wrQ.push_back(wr_t'{id: 2'(i % 4), data: 20'h00A00 + 20'(i % 4)});
      end
      @(posedge clk);
      #1;
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      req_data  = packData(20'h00A00, 20'h00A01, 20'h00A02, 20'h00A03);
      budget = 0;
      while (wrQ.size() > 0 && budget < 40) begin
         @(negedge clk);
         #1;
         budget++;
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      req_last  = '0;
      repeat (3) @(posedge clk);
      checkValue("fairPending", wrQ.size(), 0);

      // Backpressure: FIFO full for 5 cycles while beat 2 of 4 is offered.
      doReset();
      for (int i = 0; i < 4; i++) begin
         wrQ.push_back(wr_t'{id: 2'd2, data: 20'h00C01 + 20'(i)});
      end
      k        = 0;
      fullLeft = 5;
      budget   = 0;
      while (k < 4 && budget < 60) begin
         @(posedge clk);
         #1;
         req_valid = 4'b0100;
         req_data  = place(2, 20'h00C01 + 20'(k));
         req_last  = (k == 3) ? 4'b0100 : 4'b0000;
         fifo_full = (k == 1) && (fullLeft > 0);
         @(negedge clk);
         if (fifo_full) begin
            fullLeft--;
            checkValue("bpStall", {24'h0, req_ready, fifo_wen, grant_valid, grant_id},
                       {24'h0, 4'b0000, 1'b0, 1'b1, 2'd2});
         end
         if (fifo_wen === 1'b1) k++;
         budget++;
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      checkValue("bpBeats", k, 4);
      checkValue("bpFullCycles", fullLeft, 0);
      repeat (2) @(posedge clk);
      checkValue("bpPending", wrQ.size(), 0);

      // Back-to-back single-beat packets from requester 3 alone.
      doReset();
      for (int i = 0; i < 3; i++) begin
         wrQ.push_back(wr_t'{id: 2'd3, data: 20'h00D00 + 20'(i)});
      end
      k       = 0;
      budget  = 0;
      lastCyc = -10;
      while (k < 3 && budget < 20) begin
         @(posedge clk);
         #1;
         req_valid = 4'b1000;
         req_last  = 4'b1000;
         req_data  = place(3, 20'h00D00 + 20'(k));
         @(negedge clk);
         if (fifo_wen === 1'b1) begin
            if (k > 0) checkValue("singleGap", 32'((cycle - lastCyc) >= 2), 1);
            lastCyc = cycle;
            k++;
         end
         budget++;
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      req_last  = '0;
      checkValue("singleBeats", k, 3);
      repeat (2) @(posedge clk);
      checkValue("singlePending", wrQ.size(), 0);

      // Requester 0 stalls mid-packet while requester 1 waits.
      doReset();
      wrQ.push_back(wr_t'{id: 2'd0, data: 20'h00E01});
`ifdef PKT_WR_ARBITER_WDOG_EN
      wrQ.push_back(wr_t'{id: 2'd1, data: 20'h00F01});
`endif
      @(posedge clk);
      #1;
      req_valid = 4'b0011;
      req_last  = 4'b0010;
      req_data  = packData(20'h00E01, 20'h00F01, 20'h0, 20'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      req_valid = 4'b0010;
`ifdef PKT_WR_ARBITER_WDOG_EN
      // The abort edge follows the 8th stalled cycle, so the pulse is seen
      // in the 9th cycle after the last transfer.
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (wdog_err === 1'b1) seen = 1'b1;
         else @(posedge clk);
      end
      checkValue("wdogDelay", n, 9);
      checkValue("wdogIdle", {31'h0, grant_valid}, 0);
      @(negedge clk);
      checkValue("wdogNext", {28'h0, wdog_err, grant_valid, grant_id}, {28'h0, 1'b0, 1'b1, 2'd1});
      @(posedge clk);
      #1;
      req_valid = '0;
      req_last  = '0;
      repeat (2) @(posedge clk);
`else
      repeat (20) @(posedge clk);
      @(negedge clk);
      checkValue("holdGrant", {28'h0, grant_valid, grant_id, fifo_wen}, {28'h0, 1'b1, 2'd0, 1'b0});
      doReset();
      repeat (2) @(posedge clk);
`endif
      checkValue("stallPending", wrQ.size(), 0);
      monEn = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
